stack_cpu: RTL and testbench
============================

// Module: stack_cpu
// PURPOSE
//  Parametrised stack-machine core. Fetches 4-bit opcodes (low nibble of a word) from a shared
//  instruction/data memory and executes them on an internal LIFO operand stack.
//  Adds wait-state memory handshake, explicit write strobe, stack overflow/underflow faulting,
//  halt-on-RET and operand-skipping branches. Sits between the memory/IO wrapper and the host
//  result pins.
// PARAMETERS
//  DATA_W       8   word width of stack, ALU and memory data; must be >= ADDR_W
//  ADDR_W       8   memory address / PC width; operands are truncated to ADDR_W
//  STACK_DEPTH  16  operand stack entries, >= 2
// PORTS
//  clock       in   1       single clock, rising edge
//  reset_n     in   1       asynchronous active-low reset
//  mem_addr    out  ADDR_W  memory address, valid while mem_re or mem_we is high
//  mem_re      out  1       read request
//  mem_we      out  1       write request; mem_re and mem_we are never both high
//  mem_wdata   out  DATA_W  write data, valid with mem_we
//  mem_rdata   in   DATA_W  read data, sampled on the cycle mem_ready=1
//  mem_ready   in   1       request completes on any clock edge where mem_ready=1
//  result      out  DATA_W  top of stack captured by RET
//  halted      out  1       sticky; set by RET
//  fault       out  1       sticky; stack overflow/underflow
//  fault_code  out  2       01=underflow, 10=overflow, 00=none
// BEHAVIOUR
//  Reset: pc=0, sp=0, state=FETCH; all outputs 0; stack contents don't-care.
//  Opcodes: ADD0 SUB1 SHL2 SHR3 SRA4 AND5 LOR6 XOR7 PSI8 PSH9 STR10 DUP11 JPZ12 JPN13 RET14 NUL15.
//  States and transitions:
//   FETCH: mem_re=1, addr=pc; hold until mem_ready; ir<=rdata[3:0]; ->DECODE.
//   DECODE: stack check first (below), then:
//     ALU/DUP/NUL: pc+=1; ->FETCH. RET: result<=top, halted<=1; ->HALT.
//     PSI/PSH/STR: ->OPERAND. JPZ (top==0) / JPN (top[DATA_W-1]=1): ->OPERAND;
//     branch not taken: pc+=2 (skips operand word); ->FETCH.
//   OPERAND: mem_re=1, addr=pc+1; wait for ready; opr<=rdata[ADDR_W-1:0].
//     PSI: push rdata, pc+=2; ->FETCH. PSH: ->MEM_RD. STR: ->MEM_WR. JPZ/JPN: pc<=opr; ->FETCH.
//   MEM_RD: mem_re=1, addr=opr; on ready push rdata, pc+=2; ->FETCH.
//   MEM_WR: mem_we=1, addr=opr, wdata=top; on ready pop, pc+=2; ->FETCH.
//   HALT / FAULT: absorbing, no memory requests; exit only by reset.
//  Stack rules (sp = number of valid entries, 0..STACK_DEPTH):
//   ALU: needs sp>=2; b=top, a=next; pops 2, pushes a op b (net sp-1).
//   DUP needs 1<=sp<STACK_DEPTH. PSI/PSH need sp<STACK_DEPTH at the push cycle.
//   STR/JPZ/JPN/RET need sp>=1. JPZ/JPN do not pop.
//   A violation in DECODE (or at the push cycle) sets fault=1 and fault_code, and -> FAULT.
//   Stack and pc are left unchanged by the faulting instruction.
//  Arithmetic: modulo 2^DATA_W. SUB=a-b. Shift amount = b unsigned.
//   For amounts >= DATA_W: SHL/SHR give 0; SRA gives all sign bits.
//  pc wraps modulo 2^ADDR_W, including pc+1 and pc+2.
//  Latency with mem_ready tied high: ALU/DUP/NUL 2 cycles; PSI and taken branch 3; PSH/STR 4.
//   Each stall cycle extends the current state by one cycle.
//  Reset mid-operation: asserting reset_n low clears everything at once, mem_re/mem_we drop
//   asynchronously, and no write completes.
// STRUCTURE
//  Shared package stack_cpu_pkg: opcode_e (4-bit), alu_op_e, state_e, fault_code_e.
//  Sub-module stack_lifo #(DATA_W, STACK_DEPTH): push/pop/replace ports, top/next read ports,
//   sp count, full/empty flags. The ALU stays a combinational function inside stack_cpu.
// TESTING
//  1. PSI 5, PSI 3, SUB, RET -> result=0x02, halted=1, fault=0, 10 cycles with ready=1.
//  2. PSI 0x80, PSI 2, SRA, RET -> result=0xE0. PSI 1, PSI 9, SHL, RET -> result=0x00.
//  3. PSI 0, JPZ 0x10 -> pc=0x10. PSI 1, JPZ 0x10 -> pc advances by 2, no jump.
//  4. PSI 0xAA, STR 0x40, PSH 0x40, RET -> one write at addr 0x40 with wdata 0xAA;
//     result=0xAA; mem_ready held low 3 cycles per request stretches each phase exactly 3 cycles.
//  5. ADD on empty stack -> fault=1, code=01, no further mem_re.
//     STACK_DEPTH+1 x DUP after PSI 7 -> code=10.
//  6. reset_n pulsed low during a MEM_WR stall -> mem_we drops immediately;
//     after release the fetch is at addr 0, halted=0, fault=0.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared types for the stack_cpu core: opcodes, ALU selects, FSM states and fault codes.
package stack_cpu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SHL = 4'd2, OP_SHR = 4'd3,
      OP_SRA = 4'd4, OP_AND = 4'd5, OP_LOR = 4'd6, OP_XOR = 4'd7,
      OP_PSI = 4'd8, OP_PSH = 4'd9, OP_STR = 4'd10, OP_DUP = 4'd11,
      OP_JPZ = 4'd12, OP_JPN = 4'd13, OP_RET = 4'd14, OP_NUL = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_SHL, ALU_SHR, ALU_SRA, ALU_AND, ALU_LOR, ALU_XOR
   } alu_op_e;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_OPERAND, S_MEM_RD, S_MEM_WR, S_HALT, S_FAULT
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE  = 2'b00,
      FC_UNDER = 2'b01,
      FC_OVER  = 2'b10
   } fault_code_e;

   // Opcodes 0..7 are two-operand ALU operations whose low bits select alu_op_e.
   function automatic logic is_alu(opcode_e op);
      return ~op[3];
   endfunction

endpackage

// File: rtl/stack_lifo.sv
// Operand stack: push, pop, and in-place replace of top (or of next when combined with pop).
module stack_lifo #(
   parameter int DATA_W      = 8,
   parameter int STACK_DEPTH = 16,
   localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic              replace,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] top,
   output logic [DATA_W-1:0] next,
   output logic [CNT_W-1:0]  sp,
   output logic              full,
   output logic              empty
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [DATA_W-1:0] mem [STACK_DEPTH];
   logic [IDX_W-1:0]  push_idx, top_idx, next_idx;

   assign push_idx = IDX_W'(sp);
   assign top_idx  = IDX_W'(sp - CNT_W'(1));
   assign next_idx = IDX_W'(sp - CNT_W'(2));

   assign top   = mem[top_idx];
   assign next  = mem[next_idx];
   assign full  = (sp == CNT_W'(STACK_DEPTH));
   assign empty = (sp == '0);

   // pop+replace collapses two operands into one result written over next.
   always_ff @(posedge clock) begin
      if (push)
         mem[push_idx] <= wdata;
      else if (pop && replace)
         mem[next_idx] <= wdata;
      else if (replace)
         mem[top_idx] <= wdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         sp <= '0;
      else if (push && !pop)
         sp <= sp + CNT_W'(1);
      else if (pop && !push)
         sp <= sp - CNT_W'(1);
   end

endmodule

// File: rtl/stack_cpu.sv
// Stack-machine core: fetches 4-bit opcodes from a wait-stated memory and executes them on a LIFO.
//
//   state     | meaning
//   FETCH     | read opcode at pc
//   DECODE    | stack check, execute ALU/DUP/NUL/RET, resolve branch condition
//   OPERAND   | read operand word at pc+1
//   MEM_RD    | read data at operand address and push it
//   MEM_WR    | write top to operand address and pop it
//   HALT      | stopped by RET until reset
//   FAULT     | stopped by stack overflow/underflow until reset
module stack_cpu
   import stack_cpu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] result,
   output logic              halted,
   output logic              fault,
   output logic [1:0]        fault_code
);

   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam logic [DATA_W:0] SH_LIM = (DATA_W + 1)'(DATA_W);

   state_e            state;
   opcode_e           ir;
   logic [ADDR_W-1:0] pc, opr;

   logic              stk_push, stk_pop, stk_repl;
   logic [DATA_W-1:0] stk_wdata, top, next;
   logic [CNT_W-1:0]  sp;
   logic              full, empty;
   logic              under_err, over_err;

   function automatic logic [DATA_W-1:0] alu(alu_op_e op, logic [DATA_W-1:0] a,
                                             logic [DATA_W-1:0] b);
      logic big;
      big = ({1'b0, b} >= SH_LIM);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SHL: return big ? '0 : a << b;
         ALU_SHR: return big ? '0 : a >> b;
         ALU_SRA: return big ? {DATA_W{a[DATA_W-1]}} : DATA_W'($signed(a) >>> b);
         ALU_AND: return a & b;
         ALU_LOR: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   stack_lifo #(.DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) u_lifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (stk_push),
      .pop     (stk_pop),
      .replace (stk_repl),
      .wdata   (stk_wdata),
      .top     (top),
      .next    (next),
      .sp      (sp),
      .full    (full),
      .empty   (empty)
   );

   // Stack side effects and fault detection; a detected fault suppresses the stack update.
   always_comb begin
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_repl  = 1'b0;
      stk_wdata = '0;
      under_err = 1'b0;
      over_err  = 1'b0;
      case (state)
         S_DECODE: begin
            if (is_alu(ir)) begin
               if (sp < CNT_W'(2)) begin
                  under_err = 1'b1;
               end else begin
                  stk_pop   = 1'b1;
                  stk_repl  = 1'b1;
                  stk_wdata = alu(alu_op_e'(ir[2:0]), next, top);
               end
            end else begin
               case (ir)
                  OP_DUP: begin
                     if (empty)     under_err = 1'b1;
                     else if (full) over_err  = 1'b1;
                     else begin
                        stk_push  = 1'b1;
                        stk_wdata = top;
                     end
                  end
                  OP_STR, OP_JPZ, OP_JPN, OP_RET: under_err = empty;
                  default: ;
               endcase
            end
         end
         S_OPERAND, S_MEM_RD: begin
            if (mem_ready && (state == S_MEM_RD || ir == OP_PSI)) begin
               if (full) over_err = 1'b1;
               else begin
                  stk_push  = 1'b1;
                  stk_wdata = mem_rdata;
               end
            end
         end
         S_MEM_WR: stk_pop = mem_ready;
         default: ;
      endcase
   end

   // Requests are gated by reset so they vanish the instant reset_n falls.
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (reset_n) begin
         case (state)
            S_FETCH: begin
               mem_re   = 1'b1;
               mem_addr = pc;
            end
            S_OPERAND: begin
               mem_re   = 1'b1;
               mem_addr = pc + ADDR_W'(1);
            end
            S_MEM_RD: begin
               mem_re   = 1'b1;
               mem_addr = opr;
            end
            S_MEM_WR: begin
               mem_we    = 1'b1;
               mem_addr  = opr;
               mem_wdata = top;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FETCH;
         ir         <= OP_ADD;
         pc         <= '0;
         opr        <= '0;
         result     <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
      end else if (under_err || over_err) begin
         fault      <= 1'b1;
         fault_code <= under_err ? FC_UNDER : FC_OVER;
         state      <= S_FAULT;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= opcode_e'(mem_rdata[3:0]);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (ir)
                  OP_RET: begin
                     result <= top;
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  OP_PSI, OP_PSH, OP_STR: state <= S_OPERAND;
                  OP_JPZ, OP_JPN: begin
                     if ((ir == OP_JPZ) ? (top == '0) : top[DATA_W-1]) begin
                        state <= S_OPERAND;
                     end else begin
                        pc    <= pc + ADDR_W'(2);
                        state <= S_FETCH;
                     end
                  end
                  default: begin
                     pc    <= pc + ADDR_W'(1);
                     state <= S_FETCH;
                  end
               endcase
            end
            S_OPERAND: begin
               if (mem_ready) begin
                  opr <= mem_rdata[ADDR_W-1:0];
                  case (ir)
                     OP_PSI: begin
                        pc    <= pc + ADDR_W'(2);
                        state <= S_FETCH;
                     end
                     OP_PSH:  state <= S_MEM_RD;
                     OP_STR:  state <= S_MEM_WR;
                     default: begin
                        pc    <= mem_rdata[ADDR_W-1:0];
                        state <= S_FETCH;
                     end
                  endcase
               end
            end
            S_MEM_RD, S_MEM_WR: begin
               if (mem_ready) begin
                  pc    <= pc + ADDR_W'(2);
                  state <= S_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_cpu.sv
// Directed bench for stack_cpu: programs run against a wait-stated memory model, results scoreboarded.
module tb_stack_cpu;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, result;
   logic       mem_re, mem_we, halted, fault;
   logic       mem_ready = 1'b1;
   logic [1:0] fault_code;

   logic [7:0]  mem  [256];
   logic [7:0]  wmem [256];
   logic        wval [256];
   logic [15:0] wr_log [16];
   logic [7:0]  prog [$];
   logic [7:0]  exp_res_q [$];
   logic [15:0] exp_wr_q [$];

   int   wait_states = 0;
   int   ws_cnt = 0;
   logic last_req = 1'b0;
   int   wr_total = 0;
   int   re_total = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   assign mem_rdata = wval[mem_addr] ? wmem[mem_addr] : mem[mem_addr];

   stack_cpu #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .mem_addr   (mem_addr),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .result     (result),
      .halted     (halted),
      .fault      (fault),
      .fault_code (fault_code)
   );

   // Memory model: each request sees wait_states cycles of mem_ready=0; writes logged when they complete.
   always @(negedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) wval[i] = 1'b0;
         ws_cnt    = 0;
         last_req  = 1'b1;
         mem_ready = (wait_states == 0);
      end else begin
         if (!(mem_re || mem_we) || !last_req || mem_ready) ws_cnt = 0;
         else ws_cnt++;
         last_req  = mem_re || mem_we;
         mem_ready = (ws_cnt >= wait_states);
         if (mem_re) re_total++;
         if (mem_we && mem_ready) begin
            if (wr_total < 16) wr_log[wr_total] = {mem_addr, mem_wdata};
            wr_total++;
            wmem[mem_addr] = mem_wdata;
            wval[mem_addr] = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_load(input int ws);
      wait_states = ws;
      reset_n = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h0E;
      repeat (2) @(negedge clock);
   endtask

   task automatic load_at(input int base);
      for (int i = 0; i < prog.size(); i++) mem[base + i] = prog[i];
   endtask

   task automatic run(input int budget, output int cyc);
      cyc = 0;
      #2 reset_n = 1'b1;
      while (cyc < budget) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         if (halted || fault) break;
      end
   endtask

   task automatic finish_prog(input string tag, input int cyc, input int exp_cyc);
      logic [7:0] e;
      e = 8'hxx;
      if (exp_res_q.size() > 0) e = exp_res_q.pop_front();
      check({tag, "_halted"}, halted, 1);
      check({tag, "_fault"}, fault, 0);
      check({tag, "_result"}, result, e);
      check({tag, "_cycles"}, cyc, exp_cyc);
   endtask

   initial begin
      int         cyc;
      int         re0, wr0;
      logic [15:0] ew;

      reset_load(0);
      #1;
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_result", result, 0);
      check("rst_halted", halted, 0);
      check("rst_fault", fault, 0);
      check("rst_code", fault_code, 0);

      reset_load(0);
      prog = '{8'h08, 8'h05, 8'h08, 8'h03, 8'h01, 8'h0E}; load_at(0);
      exp_res_q.push_back(8'h02);
      run(100, cyc); finish_prog("sub", cyc, 10);

      reset_load(0);
      prog = '{8'h08, 8'h80, 8'h08, 8'h02, 8'h04, 8'h0E}; load_at(0);
      exp_res_q.push_back(8'hE0);
      run(100, cyc); finish_prog("sra2", cyc, 10);

      reset_load(0);
      prog = '{8'h08, 8'h01, 8'h08, 8'h09, 8'h02, 8'h0E}; load_at(0);
      exp_res_q.push_back(8'h00);
      run(100, cyc); finish_prog("shl9", cyc, 10);

      reset_load(0);
      prog = '{8'h08, 8'h80, 8'h08, 8'h09, 8'h04, 8'h0E}; load_at(0);
      exp_res_q.push_back(8'hFF);
      run(100, cyc); finish_prog("sra9", cyc, 10);

      reset_load(0);
      prog = '{8'h08, 8'h03, 8'h08, 8'h05, 8'h01, 8'h0E}; load_at(0);
      exp_res_q.push_back(8'hFE);
      run(100, cyc); finish_prog("sub_wrap", cyc, 10);

      reset_load(0);
      prog = '{8'h08, 8'h00, 8'h0C, 8'h10, 8'h0E}; load_at(0);
      prog = '{8'h08, 8'h55, 8'h0E}; load_at(16);
      exp_res_q.push_back(8'h55);
      run(100, cyc); finish_prog("jpz_taken", cyc, 11);

      reset_load(0);
      prog = '{8'h08, 8'h01, 8'h0C, 8'h10, 8'h0E}; load_at(0);
      prog = '{8'h08, 8'h55, 8'h0E}; load_at(16);
      exp_res_q.push_back(8'h01);
      run(100, cyc); finish_prog("jpz_not", cyc, 7);

      reset_load(0);
      prog = '{8'h08, 8'h80, 8'h0D, 8'h10, 8'h0E}; load_at(0);
      prog = '{8'h08, 8'h55, 8'h0E}; load_at(16);
      exp_res_q.push_back(8'h55);
      run(100, cyc); finish_prog("jpn_taken", cyc, 11);

      reset_load(3);
      prog = '{8'h08, 8'hAA, 8'h0A, 8'h40, 8'h09, 8'h40, 8'h0E}; load_at(0);
      wr0 = wr_total;
      exp_wr_q.push_back({8'h40, 8'hAA});
      exp_res_q.push_back(8'hAA);
      run(200, cyc); finish_prog("str_psh", cyc, 40);
      check("str_wr_count", wr_total - wr0, 1);
      if (wr_total > wr0 && wr0 < 16) begin
         ew = exp_wr_q.pop_front();
         check("str_wr_addr_data", wr_log[wr0], ew);
      end

      reset_load(0);
      mem[0] = 8'h00;
      run(50, cyc);
      check("add_empty_fault", fault, 1);
      check("add_empty_code", fault_code, 2'b01);
      check("add_empty_halted", halted, 0);
      check("add_empty_cycles", cyc, 2);
      re0 = re_total;
      repeat (10) @(negedge clock);
      check("fault_no_reads", re_total - re0, 0);
      check("fault_mem_re", mem_re, 0);

      reset_load(0);
      mem[0] = 8'h0E;
      run(50, cyc);
      check("ret_empty_code", fault_code, 2'b01);
      check("ret_empty_halted", halted, 0);

      reset_load(0);
      mem[0] = 8'h08; mem[1] = 8'h07;
      for (int i = 2; i < 19; i++) mem[i] = 8'h0B;
      run(100, cyc);
      check("dup_ovf_fault", fault, 1);
      check("dup_ovf_code", fault_code, 2'b10);
      check("dup_ovf_cycles", cyc, 35);

      reset_load(3);
      prog = '{8'h08, 8'hAA, 8'h0A, 8'h40, 8'h0E}; load_at(0);
      wr0 = wr_total;
      cyc = 0;
      #2 reset_n = 1'b1;
      while (!mem_we && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check("rst_mid_we_seen", mem_we, 1);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_we_drop", mem_we, 0);
      check("rst_mid_re_drop", mem_re, 0);
      wait_states = 0;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;
      #1;
      check("rst_rel_re", mem_re, 1);
      check("rst_rel_addr", mem_addr, 0);
      check("rst_rel_halted", halted, 0);
      check("rst_rel_fault", fault, 0);
      check("rst_no_write", wr_total - wr0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
